// File: rtl/rom_burst_reader.sv
// Four-channel burst reader for a 4-port ROM with a registered 1-cycle read.
// Optional per-channel response-word counters are enabled with ROM_BURST_STAT_EN.
module rom_burst_reader #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid1,
    output logic              req_ready1,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [2:0]        req_len1,
    output logic              rsp_valid1,
    input  logic              rsp_ready1,
    output logic [DATA_W-1:0] rsp_data1,
    output logic              rsp_last1,
    output logic [ADDR_W-1:0] rom_addr1,
    input  logic [DATA_W-1:0] rom_data1,
    input  logic              req_valid2,
    output logic              req_ready2,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [2:0]        req_len2,
    output logic              rsp_valid2,
    input  logic              rsp_ready2,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              rsp_last2,
    output logic [ADDR_W-1:0] rom_addr2,
    input  logic [DATA_W-1:0] rom_data2,
    input  logic              req_valid3,
    output logic              req_ready3,
    input  logic [ADDR_W-1:0] req_addr3,
    input  logic [2:0]        req_len3,
    output logic              rsp_valid3,
    input  logic              rsp_ready3,
    output logic [DATA_W-1:0] rsp_data3,
    output logic              rsp_last3,
    output logic [ADDR_W-1:0] rom_addr3,
    input  logic [DATA_W-1:0] rom_data3,
    input  logic              req_valid4,
    output logic              req_ready4,
    input  logic [ADDR_W-1:0] req_addr4,
    input  logic [2:0]        req_len4,
    output logic              rsp_valid4,
    input  logic              rsp_ready4,
    output logic [DATA_W-1:0] rsp_data4,
    output logic              rsp_last4,
    output logic [ADDR_W-1:0] rom_addr4,
    input  logic [DATA_W-1:0] rom_data4
`ifdef ROM_BURST_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_words1,
    output logic [15:0]       stat_words2,
    output logic [15:0]       stat_words3,
    output logic [15:0]       stat_words4
`endif
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned LEN_W = 3;
    localparam int unsigned OCC_W = 2;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned ENT_W = DATA_W + 1;

    typedef enum logic {IDLE, BURST} state_t;

    logic [NCH-1:0]    req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_last_a, pop_a;
    logic [ADDR_W-1:0] req_addr_a [NCH];
    logic [LEN_W-1:0]  req_len_a  [NCH];
    logic [DATA_W-1:0] rsp_data_a [NCH];
    logic [ADDR_W-1:0] rom_addr_a [NCH];
    logic [DATA_W-1:0] rom_data_a [NCH];

    assign req_valid_a = {req_valid4, req_valid3, req_valid2, req_valid1};
    assign rsp_ready_a = {rsp_ready4, rsp_ready3, rsp_ready2, rsp_ready1};
    assign req_addr_a[0] = req_addr1;
    assign req_addr_a[1] = req_addr2;
    assign req_addr_a[2] = req_addr3;
    assign req_addr_a[3] = req_addr4;
    assign req_len_a[0]  = req_len1;
    assign req_len_a[1]  = req_len2;
    assign req_len_a[2]  = req_len3;
    assign req_len_a[3]  = req_len4;
    assign rom_data_a[0] = rom_data1;
    assign rom_data_a[1] = rom_data2;
    assign rom_data_a[2] = rom_data3;
    assign rom_data_a[3] = rom_data4;

    assign {req_ready4, req_ready3, req_ready2, req_ready1} = req_ready_a;
    assign {rsp_valid4, rsp_valid3, rsp_valid2, rsp_valid1} = rsp_valid_a;
    assign {rsp_last4,  rsp_last3,  rsp_last2,  rsp_last1}  = rsp_last_a;
    assign rsp_data1 = rsp_data_a[0];
    assign rsp_data2 = rsp_data_a[1];
    assign rsp_data3 = rsp_data_a[2];
    assign rsp_data4 = rsp_data_a[3];
    assign rom_addr1 = rom_addr_a[0];
    assign rom_addr2 = rom_addr_a[1];
    assign rom_addr3 = rom_addr_a[2];
    assign rom_addr4 = rom_addr_a[3];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t            state_q, state_d;
        logic [ADDR_W-1:0] addr_cnt;
        logic [LEN_W-1:0]  rem;
        logic              pend, last_d;
        logic              issue_c, accept_c, ready_c, credit_ok_c, push_c, pop_c;
        logic [OCC_W-1:0]  occ, wr_ptr, rd_ptr;
        logic [ENT_W-1:0]  mem [DEPTH];

        // Credit: buffered words plus the one in flight must leave room in the FIFO
        assign credit_ok_c = ({1'b0, occ} + {2'b00, pend}) < 3'd3;

        always_ff @(posedge clk) begin
            if (rst) state_q <= IDLE;
            else     state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (req_valid_a[g]) state_d = BURST;
                BURST:   if (credit_ok_c && rem == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            ready_c  = 1'b0;
            issue_c  = 1'b0;
            ready_c  = (state_q == IDLE) && !rst;
            issue_c  = (state_q == BURST) && credit_ok_c;
            accept_c = ready_c && req_valid_a[g];
        end

        // Address counter, remaining count and the in-flight ROM read tag
        always_ff @(posedge clk) begin
            if (rst) begin
                addr_cnt <= '0;
                rem      <= '0;
                pend     <= 1'b0;
                last_d   <= 1'b0;
            end else begin
                pend   <= issue_c;
                last_d <= issue_c && (rem == '0);
                if (accept_c) begin
                    addr_cnt <= req_addr_a[g];
                    rem      <= req_len_a[g];
                end else if (issue_c) begin
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                    rem      <= rem - LEN_W'(1);
                end
            end
        end

        assign push_c = pend;
        assign pop_c  = (occ != '0) && rsp_ready_a[g];

        // 3-entry in-order response FIFO; head drives the response outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int k = 0; k < int'(DEPTH); k++) mem[k] <= '0;
            end else begin
                if (push_c) begin
                    mem[wr_ptr] <= {last_d, rom_data_a[g]};
                    wr_ptr      <= (wr_ptr == OCC_W'(DEPTH - 1)) ? '0 : wr_ptr + OCC_W'(1);
                end
                if (pop_c) rd_ptr <= (rd_ptr == OCC_W'(DEPTH - 1)) ? '0 : rd_ptr + OCC_W'(1);
                case ({push_c, pop_c})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end

        assign req_ready_a[g] = ready_c;
        assign rom_addr_a[g]  = addr_cnt;
        assign rsp_valid_a[g] = (occ != '0);
        assign {rsp_last_a[g], rsp_data_a[g]} = mem[rd_ptr];
        assign pop_a[g] = pop_c;
    end

`ifdef ROM_BURST_STAT_EN
    logic [15:0] stat_q [NCH];

    // Saturating popped-word counters; clear dominates a same-cycle pop
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NCH); i++) begin
            if (rst || stat_clr)                     stat_q[i] <= '0;
            else if (pop_a[i] && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
        end
    end

    assign stat_words1 = stat_q[0];
    assign stat_words2 = stat_q[1];
    assign stat_words3 = stat_q[2];
    assign stat_words4 = stat_q[3];
`else
    logic unused_pop;
    assign unused_pop = ^pop_a;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed timing checks plus randomized traffic against
// a per-channel expected-word queue built from the ROM contents and burst rules.
module tb_rom_burst_reader;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid [NCH];
    logic       req_ready [NCH];
    logic [2:0] req_addr  [NCH];
    logic [2:0] req_len   [NCH];
    logic       rsp_valid [NCH];
    logic       rsp_ready [NCH];
    logic [7:0] rsp_data  [NCH];
    logic       rsp_last  [NCH];
    logic [2:0] rom_addr  [NCH];
    logic [7:0] rom_data  [NCH];
    logic [7:0] rom_mem   [8];
    logic [8:0] expq [NCH][$];
`ifdef ROM_BURST_STAT_EN
    logic        stat_clr;
    logic [15:0] stat_words [NCH];
`endif

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    // Four-port ROM with registered read
    always @(posedge clk)
        for (int i = 0; i < NCH; i++) rom_data[i] <= rom_mem[rom_addr[i]];

    rom_burst_reader dut (
        .clk(clk), .rst(rst),
        .req_valid1(req_valid[0]), .req_ready1(req_ready[0]), .req_addr1(req_addr[0]), .req_len1(req_len[0]),
        .rsp_valid1(rsp_valid[0]), .rsp_ready1(rsp_ready[0]), .rsp_data1(rsp_data[0]), .rsp_last1(rsp_last[0]),
        .rom_addr1(rom_addr[0]), .rom_data1(rom_data[0]),
        .req_valid2(req_valid[1]), .req_ready2(req_ready[1]), .req_addr2(req_addr[1]), .req_len2(req_len[1]),
        .rsp_valid2(rsp_valid[1]), .rsp_ready2(rsp_ready[1]), .rsp_data2(rsp_data[1]), .rsp_last2(rsp_last[1]),
        .rom_addr2(rom_addr[1]), .rom_data2(rom_data[1]),
        .req_valid3(req_valid[2]), .req_ready3(req_ready[2]), .req_addr3(req_addr[2]), .req_len3(req_len[2]),
        .rsp_valid3(rsp_valid[2]), .rsp_ready3(rsp_ready[2]), .rsp_data3(rsp_data[2]), .rsp_last3(rsp_last[2]),
        .rom_addr3(rom_addr[2]), .rom_data3(rom_data[2]),
        .req_valid4(req_valid[3]), .req_ready4(req_ready[3]), .req_addr4(req_addr[3]), .req_len4(req_len[3]),
        .rsp_valid4(rsp_valid[3]), .rsp_ready4(rsp_ready[3]), .rsp_data4(rsp_data[3]), .rsp_last4(rsp_last[3]),
        .rom_addr4(rom_addr[3]), .rom_data4(rom_data[3])
`ifdef ROM_BURST_STAT_EN
        ,
        .stat_clr(stat_clr),
        .stat_words1(stat_words[0]), .stat_words2(stat_words[1]),
        .stat_words3(stat_words[2]), .stat_words4(stat_words[3])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NCH; i++) s += expq[i].size();
        return s;
    endfunction

    // One clock: score handshakes and visible response words, then advance to the next negedge
    task automatic cyc();
        #1;
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) expq[ch].delete();
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (req_valid[ch] && req_ready[ch])
                    for (int i = 0; i <= int'(req_len[ch]); i++)
                        expq[ch].push_back({i == int'(req_len[ch]), rom_mem[(int'(req_addr[ch]) + i) % 8]});
                if (rsp_valid[ch]) begin
                    if (expq[ch].size() == 0)
                        chk($sformatf("rsp_spurious_ch%0d", ch + 1), 32'(rsp_valid[ch]), 32'd0);
                    else begin
                        chk($sformatf("rsp_word_ch%0d", ch + 1), {23'd0, rsp_last[ch], rsp_data[ch]}, 32'(expq[ch][0]));
                        if (rsp_ready[ch]) void'(expq[ch].pop_front());
                    end
                end
            end
        end
        @(negedge clk);
        cycle++;
    endtask

    task automatic drain(input string tag);
        for (int ch = 0; ch < NCH; ch++) begin
            req_valid[ch] = 1'b0;
            rsp_ready[ch] = 1'b1;
        end
        for (int n = 0; n < 300 && pending() > 0; n++) cyc();
        chk(tag, 32'(pending()), 32'd0);
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 8; i++) rom_mem[i] = {5'($urandom), 3'(i)};
        for (int ch = 0; ch < NCH; ch++) begin
            req_valid[ch] = 1'b0;
            req_addr[ch]  = '0;
            req_len[ch]   = '0;
            rsp_ready[ch] = 1'b0;
        end
`ifdef ROM_BURST_STAT_EN
        stat_clr = 1'b0;
`endif
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            chk("reset_req_ready", 32'(req_ready[ch]), 32'd0);
            chk("reset_rsp_valid", 32'(rsp_valid[ch]), 32'd0);
            chk("reset_rsp_data",  32'(rsp_data[ch]),  32'd0);
            chk("reset_rsp_last",  32'(rsp_last[ch]),  32'd0);
            chk("reset_rom_addr",  32'(rom_addr[ch]),  32'd0);
        end
        cyc();
        rst = 1'b0;
        cyc();
        for (int ch = 0; ch < NCH; ch++) chk("idle_req_ready", 32'(req_ready[ch]), 32'd1);

        // Single word on ch1, addr 5
        req_valid[0] = 1'b1; req_addr[0] = 3'd5; req_len[0] = 3'd0; rsp_ready[0] = 1'b1;
        cyc();
        req_valid[0] = 1'b0;
        chk("t1_valid_T1", 32'(rsp_valid[0]), 32'd0);
        chk("t1_ready_T1", 32'(req_ready[0]), 32'd0);
        cyc();
        chk("t1_ready_T2", 32'(req_ready[0]), 32'd1);
        chk("t1_valid_T2", 32'(rsp_valid[0]), 32'd0);
        cyc();
        chk("t1_valid_T3", 32'(rsp_valid[0]), 32'd1);
        chk("t1_data_T3",  32'(rsp_data[0]),  32'(rom_mem[5]));
        chk("t1_last_T3",  32'(rsp_last[0]),  32'd1);
        cyc();
        chk("t1_valid_T4", 32'(rsp_valid[0]), 32'd0);

        // Wrapping burst on ch2: 6,7,0,1
        req_valid[1] = 1'b1; req_addr[1] = 3'd6; req_len[1] = 3'd3; rsp_ready[1] = 1'b1;
        cyc();
        req_valid[1] = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("wrap_valid", 32'(rsp_valid[1]), 32'd1);
            chk("wrap_data",  32'(rsp_data[1]),  32'(rom_mem[(6 + i) % 8]));
            chk("wrap_last",  32'(rsp_last[1]),  32'(i == 3));
        end
        cyc();
        chk("wrap_after", 32'(rsp_valid[1]), 32'd0);

        // Backpressure on ch3: three reads issued, then stalled with addr counter at 3
        req_valid[2] = 1'b1; req_addr[2] = 3'd0; req_len[2] = 3'd7; rsp_ready[2] = 1'b0;
        cyc();
        req_valid[2] = 1'b0;
        repeat (9) cyc();
        chk("bp_valid",    32'(rsp_valid[2]), 32'd1);
        chk("bp_head",     32'(rsp_data[2]),  32'(rom_mem[0]));
        chk("bp_rom_addr", 32'(rom_addr[2]),  32'd3);
        drain("bp_drain");

        // Concurrent requests on all channels with random downstream readiness
        for (int ch = 0; ch < NCH; ch++) begin
            req_valid[ch] = 1'b1;
            req_addr[ch]  = 3'($urandom);
            req_len[ch]   = 3'($urandom);
            rsp_ready[ch] = 1'($urandom);
        end
        cyc();
        for (int n = 0; n < 30; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                req_valid[ch] = 1'b0;
                rsp_ready[ch] = 1'($urandom);
            end
            cyc();
        end
        drain("conc_drain");

        // Reset during word 2 of an 8-word burst on ch4
        req_valid[3] = 1'b1; req_addr[3] = 3'($urandom); req_len[3] = 3'd7; rsp_ready[3] = 1'b1;
        cyc();
        req_valid[3] = 1'b0;
        cyc();
        cyc();
        chk("rst_w0_valid", 32'(rsp_valid[3]), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst_req_ready", 32'(req_ready[3]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[3]), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_valid", 32'(rsp_valid[3]), 32'd0);
        chk("post_rst_ready", 32'(req_ready[3]), 32'd1);
        repeat (3) begin
            cyc();
            chk("post_rst_no_stale", 32'(rsp_valid[3]), 32'd0);
        end
        req_valid[3] = 1'b1; req_addr[3] = 3'd3; req_len[3] = 3'($urandom);
        cyc();
        req_valid[3] = 1'b0;
        cyc();
        cyc();
        chk("post_rst_first_valid", 32'(rsp_valid[3]), 32'd1);
        chk("post_rst_first_data",  32'(rsp_data[3]),  32'(rom_mem[3]));
        drain("post_rst_drain");

        // Random traffic on all channels
        for (int n = 0; n < 400; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                req_valid[ch] = ($urandom % 3) == 0;
                req_addr[ch]  = 3'($urandom);
                req_len[ch]   = 3'($urandom);
                rsp_ready[ch] = ($urandom % 4) != 0;
            end
            cyc();
        end
        drain("rand_drain");

`ifdef ROM_BURST_STAT_EN
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("stat_cleared", 32'(stat_words[0]), 32'd0);
        for (int b = 0; b < 2; b++) begin
            req_valid[0] = 1'b1; req_addr[0] = 3'($urandom); req_len[0] = 3'd7;
            cyc();
            drain("stat_burst_drain");
        end
        chk("stat_16", 32'(stat_words[0]), 32'd16);
        req_valid[0] = 1'b1; req_addr[0] = 3'($urandom); req_len[0] = 3'd7;
        cyc();
        req_valid[0] = 1'b0;
        cyc();
        cyc();
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("stat_clr_wins", 32'(stat_words[0]), 32'd0);
        drain("stat_tail_drain");
        chk("stat_tail_7", 32'(stat_words[0]), 32'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
